// File: rtl/mult_arbiter.sv
// mult_arbiter
//   Round-robin arbiter that shares one serial mantissa multiplier between
//   two requesters. A grant latches the winner's operands, pulses the
//   multiplier's active-low load (m_RST) for one cycle, then waits for
//   m_enaout or for TMO RUN cycles (timeout) before reporting back.
//
// Ports
//   CLK, RST              rising-edge clock, asynchronous active-low reset
//   req0/req1             level requests, held until the matching done pulse
//   A0/B0, A1/B1 [23:0]   requester operands
//   done0/done1           one-cycle completion pulse (never both high)
//   out0/out1 [23:0]      result, updated with done, held otherwise
//   err0/err1             timeout flag, valid with done
//   m_A/m_B [23:0]        operands to the multiplier (held until next grant)
//   m_RST                 active-low load/reset to the multiplier
//   m_out [23:0]          multiplier result
//   m_enaout              multiplier finished flag
// Parameter
//   TMO                   RUN-state cycle limit before timeout (>= 1)

module mult_arbiter #(
    parameter int TMO = 32
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        req0,
    input  logic [23:0] A0,
    input  logic [23:0] B0,
    output logic        done0,
    output logic [23:0] out0,
    output logic        err0,
    input  logic        req1,
    input  logic [23:0] A1,
    input  logic [23:0] B1,
    output logic        done1,
    output logic [23:0] out1,
    output logic        err1,
    output logic [23:0] m_A,
    output logic [23:0] m_B,
    output logic        m_RST,
    input  logic [23:0] m_out,
    input  logic        m_enaout
);

    localparam int CW = $clog2(TMO + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t          state_r;
    logic            grant_r;   // port currently being served
    logic            last_r;    // port granted most recently
    logic [CW-1:0]   cnt_r;     // RUN cycles elapsed
    logic            grant_s;
    logic            req_any_s;
    logic            timeout_s;

    // Round-robin choice: on a tie the port not served last wins.
    always_comb begin
        req_any_s = req0 | req1;
        if (req0 && req1) begin
            grant_s = ~last_r;
        end else if (req1) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
        timeout_s = (cnt_r == CW'(TMO - 1));
    end

    // Control FSM with all outputs registered.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_r <= IDLE;
            grant_r <= 1'b0;
            last_r  <= 1'b1;          // port 0 wins the first tie
            cnt_r   <= {CW{1'b0}};
            m_A     <= 24'd0;
            m_B     <= 24'd0;
            m_RST   <= 1'b0;          // hold multiplier in reset
            out0    <= 24'd0;
            out1    <= 24'd0;
            err0    <= 1'b0;
            err1    <= 1'b0;
            done0   <= 1'b0;
            done1   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done0 <= 1'b0;
                    done1 <= 1'b0;
                    if (req_any_s) begin
                        grant_r <= grant_s;
                        last_r  <= grant_s;
                        m_A     <= grant_s ? A1 : A0;
                        m_B     <= grant_s ? B1 : B0;
                        m_RST   <= 1'b0;   // load pulse for the multiplier
                        state_r <= LOAD;
                    end else begin
                        m_RST   <= 1'b1;
                    end
                end
                LOAD: begin
                    m_RST   <= 1'b1;
                    cnt_r   <= {CW{1'b0}};
                    state_r <= RUN;
                end
                RUN: begin
                    if (m_enaout) begin
                        if (grant_r) begin
                            out1  <= m_out;
                            err1  <= 1'b0;
                            done1 <= 1'b1;
                        end else begin
                            out0  <= m_out;
                            err0  <= 1'b0;
                            done0 <= 1'b1;
                        end
                        state_r <= DONE;
                    end else if (timeout_s) begin
                        // Result left untouched; only the error flag moves.
                        if (grant_r) begin
                            err1  <= 1'b1;
                            done1 <= 1'b1;
                        end else begin
                            err0  <= 1'b1;
                            done0 <= 1'b1;
                        end
                        state_r <= DONE;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                DONE: begin
                    done0   <= 1'b0;
                    done1   <= 1'b0;
                    cnt_r   <= {CW{1'b0}};
                    state_r <= IDLE;
                end
                default: begin
                    done0   <= 1'b0;
                    done1   <= 1'b0;
                    cnt_r   <= {CW{1'b0}};
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_arbiter.sv
// Testbench for mult_arbiter: a transaction-level reference model predicts
// each completion (port, cycle, result, error) into a queue; a monitor on
// the falling edge pops and compares whenever a done pulse appears, and
// also tracks the expected values of every held output.

module tb_mult_arbiter;

    localparam int TMO = 32;
    localparam int LAT = 26;          // grant edge to done cycle, normal op

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [23:0] A0 = 24'd0, B0 = 24'd0, A1 = 24'd0, B1 = 24'd0;
    logic        done0, done1, err0, err1, m_RST;
    logic [23:0] out0, out1, m_A, m_B, m_out;
    logic        m_enaout;
    logic        stall = 1'b0;        // multiplier never finishes when set
    logic [4:0]  mcnt = 5'd0;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    mult_arbiter #(.TMO(TMO)) dut (
        .CLK(CLK), .RST(RST),
        .req0(req0), .A0(A0), .B0(B0), .done0(done0), .out0(out0), .err0(err0),
        .req1(req1), .A1(A1), .B1(B1), .done1(done1), .out1(out1), .err1(err1),
        .m_A(m_A), .m_B(m_B), .m_RST(m_RST), .m_out(m_out), .m_enaout(m_enaout)
    );

    always #5 CLK = ~CLK;

    // Mantissa product: 1.23 fixed point times 1.23, truncated to 24 bits.
    function automatic logic [23:0] mul(input logic [23:0] a, input logic [23:0] b);
        logic [47:0] p;
        p = {24'd0, a} * {24'd0, b};
        return p[46:23];
    endfunction

    // 24-step serial multiplier model: finished flag rises in the 24th cycle
    // after load release and stays high (exercises ignore-outside-RUN).
    always @(posedge CLK) begin
        if (!m_RST) mcnt <= 5'd0;
        else if (mcnt != 5'd31) mcnt <= mcnt + 5'd1;
    end
    assign m_enaout = m_RST && !stall && (mcnt >= 5'd23);
    assign m_out    = mul(m_A, m_B);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int          port;
        logic [23:0] out;
        logic        err;
        int          due;
    } exp_t;

    exp_t        q[$];
    int          busy = 0;
    int          last = 1;
    logic [23:0] out_pred [2];
    logic        mrst_exp = 1'b0;
    logic [23:0] ma_exp = 24'd0, mb_exp = 24'd0;

    initial begin
        exp_t e;
        int g, lat;
        logic [23:0] a, b;
        out_pred[0] = 24'd0;
        out_pred[1] = 24'd0;
        forever begin
            @(posedge CLK or negedge RST);
            if (!RST) begin
                q.delete();
                busy = 0; last = 1; mrst_exp = 1'b0;
                ma_exp = 24'd0; mb_exp = 24'd0;
                out_pred[0] = 24'd0; out_pred[1] = 24'd0;
            end else begin
                cyc++;
                if (busy > 0) begin
                    busy--;
                    mrst_exp = 1'b1;
                end else if (req0 || req1) begin
                    g = (req0 && req1) ? 1 - last : (req1 ? 1 : 0);
                    last = g;
                    a = (g == 1) ? A1 : A0;
                    b = (g == 1) ? B1 : B0;
                    lat = stall ? TMO + 2 : LAT;
                    e.port = g;
                    e.err  = stall;
                    e.out  = stall ? out_pred[g] : mul(a, b);
                    e.due  = cyc + lat - 1;
                    out_pred[g] = e.out;
                    q.push_back(e);
                    busy = lat;
                    mrst_exp = 1'b0;
                    ma_exp = a; mb_exp = b;
                end else begin
                    mrst_exp = 1'b1;
                end
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    logic [23:0] exp_out [2];
    logic        exp_err [2];
    int          done_log[$];

    initial begin
        exp_t e;
        int p;
        exp_out[0] = 24'd0; exp_out[1] = 24'd0;
        exp_err[0] = 1'b0;  exp_err[1] = 1'b0;
        forever begin
            @(negedge CLK);
            if (!RST) begin
                exp_out[0] = 24'd0; exp_out[1] = 24'd0;
                exp_err[0] = 1'b0;  exp_err[1] = 1'b0;
                chk("rst_done", {done0, done1}, 2'b00);
                chk("rst_out", {out0, out1}, 48'd0);
                chk("rst_err", {err0, err1}, 2'b00);
                chk("rst_mab", {m_A, m_B}, 48'd0);
                chk("rst_mrst", m_RST, 1'b0);
            end else begin
                chk("done_excl", done0 & done1, 1'b0);
                if (done0 || done1) begin
                    p = done1 ? 1 : 0;
                    done_log.push_back(p);
                    if (q.size() == 0) begin
                        chk("unexpected_done", p, 32'hFFFF);
                    end else begin
                        e = q.pop_front();
                        chk("done_port", p, e.port);
                        chk("done_cycle", cyc, e.due);
                        chk("done_out", (p == 1) ? out1 : out0, e.out);
                        chk("done_err", (p == 1) ? err1 : err0, e.err);
                        exp_out[e.port] = e.out;
                        exp_err[e.port] = e.err;
                    end
                end else if (q.size() > 0 && cyc > q[0].due) begin
                    e = q.pop_front();
                    chk("missed_done_cycle", cyc, e.due);
                end
                chk("out0_hold", out0, exp_out[0]);
                chk("out1_hold", out1, exp_out[1]);
                chk("err0_hold", err0, exp_err[0]);
                chk("err1_hold", err1, exp_err[1]);
                chk("m_A", m_A, ma_exp);
                chk("m_B", m_B, mb_exp);
                chk("m_RST", m_RST, mrst_exp);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_done(input int port, input int limit);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            @(negedge CLK);
            if ((port == 1) ? done1 : done0) seen = 1'b1;
        end
        chk("wait_done", seen, 1'b1);
    endtask

    task automatic do_reset(input int cycles);
        @(posedge CLK); #2;
        RST = 1'b0;
        req0 = 1'b0; req1 = 1'b0;
        repeat (cycles) @(negedge CLK);
        @(posedge CLK); #2;
        RST = 1'b1;
    endtask

    initial begin
        logic [23:0] ra, rb;
        bit seen;
        int p;

        // reset and release
        repeat (3) @(negedge CLK);
        @(posedge CLK); #2;
        RST = 1'b1;
        @(negedge CLK);
        chk("m_rst_before_edge", m_RST, 1'b0);
        @(negedge CLK);
        chk("m_rst_after_edge", m_RST, 1'b1);

        // single request with known operands
        A0 = 24'h800000; B0 = 24'hC00000; req0 = 1'b1;
        wait_done(0, LAT + 5);
        req0 = 1'b0;
        chk("single_out0", out0, 24'hC00000);
        chk("single_err0", err0, 1'b0);

        // simultaneous requests after reset, fairness over 6 operations
        do_reset(2);
        @(negedge CLK);
        done_log.delete();
        A0 = 24'($urandom); B0 = 24'($urandom) | 24'h800000;
        A1 = 24'($urandom); B1 = 24'($urandom) | 24'h800000;
        req0 = 1'b1; req1 = 1'b1;
        for (int k = 0; k < 6; k++) begin
            seen = 1'b0;
            for (int i = 0; i < LAT + 5 && !seen; i++) begin
                @(negedge CLK);
                if (done0 || done1) seen = 1'b1;
            end
            chk("fair_wait", seen, 1'b1);
            p = done1 ? 1 : 0;
            if (p == 1) begin A1 = 24'($urandom); B1 = 24'($urandom); end
            else        begin A0 = 24'($urandom); B0 = 24'($urandom); end
        end
        req0 = 1'b0; req1 = 1'b0;
        repeat (2) @(negedge CLK);
        chk("fair_count", done_log.size(), 6);
        for (int i = 0; i < 6 && i < done_log.size(); i++)
            chk("fair_order", done_log[i], i % 2);

        // timeout, then a normal request on the same port
        stall = 1'b1;
        A1 = 24'($urandom); B1 = 24'($urandom);
        req1 = 1'b1;
        wait_done(1, TMO + 10);
        req1 = 1'b0;
        chk("tmo_err1", err1, 1'b1);
        repeat (2) @(negedge CLK);
        stall = 1'b0;
        ra = 24'($urandom); rb = 24'($urandom);
        A1 = ra; B1 = rb; req1 = 1'b1;
        wait_done(1, LAT + 5);
        req1 = 1'b0;
        chk("post_tmo_err1", err1, 1'b0);
        chk("post_tmo_out1", out1, mul(ra, rb));

        // reset in the middle of RUN
        A0 = 24'($urandom); B0 = 24'($urandom); req0 = 1'b1;
        repeat (10) @(negedge CLK);
        do_reset(3);
        @(negedge CLK);
        chk("after_rst_out0", out0, 24'd0);
        ra = 24'($urandom); rb = 24'($urandom);
        A0 = ra; B0 = rb; req0 = 1'b1;
        wait_done(0, LAT + 5);
        req0 = 1'b0;
        chk("fresh_out0", out0, mul(ra, rb));

        // withdrawal during RUN: operation still completes, no new grant
        ra = 24'($urandom); rb = 24'($urandom);
        A1 = ra; B1 = rb; req1 = 1'b1;
        repeat (6) @(negedge CLK);
        req1 = 1'b0;
        A1 = 24'($urandom);           // ignored after the grant
        wait_done(1, LAT + 5);
        chk("withdraw_out1", out1, mul(ra, rb));
        repeat (10) @(negedge CLK);
        chk("withdraw_idle_mrst", m_RST, 1'b1);

        // randomized traffic, operands may wiggle while requests are high
        for (int i = 0; i < 600; i++) begin
            @(negedge CLK);
            if ($urandom_range(0, 7) == 0) req0 = ~req0;
            if ($urandom_range(0, 7) == 0) req1 = ~req1;
            if ($urandom_range(0, 3) == 0) begin A0 = 24'($urandom); B0 = 24'($urandom); end
            if ($urandom_range(0, 3) == 0) begin A1 = 24'($urandom); B1 = 24'($urandom); end
        end
        req0 = 1'b0; req1 = 1'b0;
        repeat (TMO + 40) @(negedge CLK);
        chk("drain_queue", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1);
    end

endmodule

// File: doc/mult_arbiter.md
MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: CLK input 1 (rising-edge clock); RST input 1 (asynchronous active-low reset).
REQ-002 The block SHALL have these requester ports, with x = 0 and x = 1:
- reqx input 1: level request, held until donex.
- Ax, Bx input 24: mantissa operands; stable while reqx is high.
- donex output 1: one-cycle completion pulse.
- outx output 24: result; valid when donex is high, holds otherwise.
- errx output 1: timeout flag; valid with donex.
REQ-003 The block SHALL have these multiplier-side ports:
- m_A, m_B output 24: operands to the shared serial mantissa multiplier.
- m_RST output 1: active-low load/reset to the multiplier, registered.
- m_out input 24: multiplier result.
- m_enaout input 1: multiplier finished flag.
REQ-004 The block SHALL have one parameter: TMO, default 32, the RUN-state cycle limit before timeout.

Function
REQ-005 The FSM SHALL have four states: IDLE, LOAD, RUN, DONE.
REQ-006 IDLE: if any reqx is high, the block SHALL grant one port and go to LOAD; otherwise it stays in IDLE.
REQ-007 Arbitration SHALL be round-robin:
- Only one request high: grant that port.
- Both high: grant the port not granted last.
- The last-grant pointer resets so that port 0 wins the first tie.
REQ-008 On the IDLE->LOAD edge the block SHALL latch the granted Ax/Bx into m_A/m_B, drive m_RST=0, and record the grant index.
REQ-009 m_A/m_B SHALL hold the latched values until the next grant, so operand changes on the requester side after the grant are ignored.
REQ-010 LOAD SHALL last exactly one cycle; on the LOAD->RUN edge m_RST returns to 1.
REQ-011 RUN: the block SHALL count cycles.
- When m_enaout is sampled high: capture m_out into the granted port's outx, clear errx, go to DONE.
- When the count reaches TMO with m_enaout still low: leave outx unchanged, set errx, go to DONE.
REQ-012 DONE SHALL last one cycle: donex=1 for the granted port only, then return to IDLE; the RUN counter clears.
REQ-013 Latency with a compliant 24-step multiplier: donex SHALL be high in the 26th cycle after the IDLE->LOAD edge, and the block returns to IDLE one edge later.
REQ-014 Lowering reqx during LOAD or RUN SHALL NOT abort the operation: it completes, donex still pulses, and the requester may ignore it.
REQ-015 A reqx still high in the IDLE cycle after DONE SHALL be treated as a new request and re-arbitrated under REQ-007.
REQ-016 At most one donex SHALL be high in any cycle; done0 and done1 are never high together.
REQ-017 m_enaout high while in IDLE, LOAD or DONE SHALL be ignored.
REQ-018 outx/errx of the non-granted port SHALL never change.

Reset
REQ-019 While RST=0, the block SHALL hold these values:
- State = IDLE.
- m_RST = 0, so the multiplier is held in reset.
- m_A = m_B = 0.
- out0 = out1 = 0.
- done0 = done1 = 0.
- err0 = err1 = 0.
- RUN counter = 0.
- Last-grant pointer = port 1, so port 0 wins the first tie.
REQ-020 After RST rises, m_RST SHALL go to 1 on the first clock edge in IDLE.
REQ-021 Reset asserted mid-operation SHALL immediately discard the operation, apply the REQ-019 values, and produce no donex.

Verification
REQ-022 Single request: req0=1, A0=24'h800000, B0=24'hC00000 -> done0 exactly 26 cycles after the grant edge, out0=24'hC00000, err0=0, done1 never high.
REQ-023 Simultaneous requests after reset: req0=req1=1, held until each is served -> port 0 served first; port 1 is granted in the IDLE cycle after done0; done0 and done1 never high together.
REQ-024 Fairness: both requests held high for 6 operations -> grant order is 0,1,0,1,0,1.
REQ-025 Timeout: multiplier model keeps m_enaout=0 -> done with errx=1 after TMO RUN cycles; outx unchanged; the next request proceeds normally.
REQ-026 Reset mid-RUN: pulse RST low at cycle 10 of RUN -> all outputs at reset values, no donex; a fresh request afterwards completes with the correct result.
REQ-027 Request withdrawal: drop req1 during RUN -> done1 still pulses, out1 updated; IDLE is entered with no new grant.
